// File: rtl/mem_pkg.sv
// Shared constants and types for the mem_responder register-file target.
package mem_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2**ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_op_e;

  typedef struct packed {
    logic  valid;
    data_t data;
    logic  err;
  } rd_slot_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// RD_LAT-stage delay line of read slots; the last stage holds its data while
// idle and only reports err alongside a valid result.
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter type         slot_t     = rd_slot_t,
  parameter slot_t       RESET_SLOT = '0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  slot_t slot_in,
  output slot_t slot_out
);

  slot_t stage_q [RD_LAT];
  slot_t stage_d [RD_LAT];

  always_comb begin
    stage_d[0] = slot_in;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    // Output stage: keep last returned data across write slots.
    if (!stage_d[RD_LAT-1].valid) begin
      stage_d[RD_LAT-1].data = stage_q[RD_LAT-1].data;
      stage_d[RD_LAT-1].err  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        stage_q[i] <= RESET_SLOT;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign slot_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Register-file memory target with RD_LAT read pipeline, written bitmap and
// read-of-unwritten flag. Optional counters: MEM_RESPONDER_STATS_EN.
module mem_responder #(
  parameter int unsigned ADDR_W    = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W    = mem_pkg::DATA_W,
  parameter int unsigned RD_LAT    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_rdn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              rd_err
`ifdef MEM_RESPONDER_STATS_EN
  ,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       err_cnt
`endif
);
  import mem_pkg::*;

  localparam int unsigned N_ENTRIES = 2**ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              err;
  } slot_t;

  localparam slot_t RESET_SLOT = '{valid: 1'b0, data: RESET_VAL, err: 1'b0};

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("mem_responder: RD_LAT=%0d outside legal range 1..4", RD_LAT);
  end

  mem_op_e op;
  assign op = mem_op_e'(wr_rdn);

  logic [DATA_W-1:0]    mem_q [N_ENTRIES];
  logic [DATA_W-1:0]    mem_d [N_ENTRIES];
  logic [N_ENTRIES-1:0] written_q, written_d;
  logic                 rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  slot_t                slot_in, slot_out;

  // The read request is registered and the array sampled one edge later, so
  // a write in the same cycle as the read's first pipe stage is not visible.
  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    rd_req_d  = (op == MEM_RD);
    rd_addr_d = addr;
    if (op == MEM_WR) begin
      mem_d[addr]     = in_data;
      written_d[addr] = 1'b1;
    end
    slot_in.valid = rd_req_q;
    slot_in.data  = mem_q[rd_addr_q];
    slot_in.err   = ~written_q[rd_addr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        mem_q[i] <= RESET_VAL;
      end
      written_q <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      mem_q     <= mem_d;
      written_q <= written_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  mem_rd_pipe #(
    .RD_LAT    (RD_LAT),
    .slot_t    (slot_t),
    .RESET_SLOT(RESET_SLOT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .slot_in (slot_in),
    .slot_out(slot_out)
  );

  assign out_data  = slot_out.data;
  assign out_valid = slot_out.valid;
  assign rd_err    = slot_out.valid & slot_out.err;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    if (op == MEM_WR && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 16'd1;
    if (op == MEM_RD && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 16'd1;
    if (out_valid && rd_err && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wr_cnt  = wr_cnt_q;
  assign rd_cnt  = rd_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: three responders (RD_LAT 1, 2, 3) share one stimulus stream.
module tb_mem_responder;

  logic       clk;
  logic       rst_n;
  logic       wr_rdn;
  logic [3:0] addr;
  logic [7:0] in_data;

  logic [7:0] d1, d2, d3;
  logic       v1, v2, v3;
  logic       e1, e2, e3;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] wc1, rc1, ec1, wc2, rc2, ec2, wc3, rc3, ec3;
`endif

  int vectors;
  int miscompares;

  mem_responder #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .wr_rdn(wr_rdn), .addr(addr), .in_data(in_data),
    .out_data(d1), .out_valid(v1), .rd_err(e1)
`ifdef MEM_RESPONDER_STATS_EN
    , .wr_cnt(wc1), .rd_cnt(rc1), .err_cnt(ec1)
`endif
  );

  mem_responder #(.RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .wr_rdn(wr_rdn), .addr(addr), .in_data(in_data),
    .out_data(d2), .out_valid(v2), .rd_err(e2)
`ifdef MEM_RESPONDER_STATS_EN
    , .wr_cnt(wc2), .rd_cnt(rc2), .err_cnt(ec2)
`endif
  );

  mem_responder #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .wr_rdn(wr_rdn), .addr(addr), .in_data(in_data),
    .out_data(d3), .out_valid(v3), .rd_err(e3)
`ifdef MEM_RESPONDER_STATS_EN
    , .wr_cnt(wc3), .rd_cnt(rc3), .err_cnt(ec3)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One transaction per rising edge; returns 1ns after that edge.
  task automatic drive(input logic wr, input logic [3:0] a, input logic [7:0] d);
    wr_rdn  = wr;
    addr    = a;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) drive(1'b1, 4'hD, 8'hDD);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_rdn = 1'b0; addr = '0; in_data = '0;
    #12;
    vectors++;
    if ({v1, e1, d1, v2, e2, d2, v3, e3, d3} !== 30'd0) begin
      $display("FAIL reset_outputs: got %h expected 0", {v1, e1, d1, v2, e2, d2, v3, e3, d3});
      miscompares++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unwritten_reads();
    for (int i = 0; i <= 16; i++) begin
      drive(1'b0, 4'(i % 16), 8'h00);
      if (i > 0) begin
        vectors++;
        if ({v1, e1, d1} !== {1'b1, 1'b1, 8'h00}) begin
          $display("FAIL unwritten_read[%0d]: got v=%b e=%b d=%h expected v=1 e=1 d=00", i - 1, v1, e1, d1);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'h3, 8'hA5);
    drive(1'b1, 4'hF, 8'h5A);
    drive(1'b0, 4'h3, 8'h00);
    drive(1'b0, 4'hF, 8'h00);
    vectors++;
    if ({v1, e1, d1} !== {1'b1, 1'b0, 8'hA5}) begin
      $display("FAIL b2b_first: got v=%b e=%b d=%h expected v=1 e=0 d=a5", v1, e1, d1);
      miscompares++;
    end
    drive(1'b1, 4'h9, 8'h99);
    vectors++;
    if ({v1, e1, d1} !== {1'b1, 1'b0, 8'h5A}) begin
      $display("FAIL b2b_second: got v=%b e=%b d=%h expected v=1 e=0 d=5a", v1, e1, d1);
      miscompares++;
    end
  endtask

  task automatic test_raw_lat3();
    flush();
    for (int k = 0; k < 6; k++) begin
      if (k == 0)      drive(1'b1, 4'h7, 8'h3C);
      else if (k == 1) drive(1'b0, 4'h7, 8'h00);
      else             drive(1'b1, 4'hD, 8'hDD);
      vectors++;
      if (v3 !== (k == 4) || e3 !== 1'b0) begin
        $display("FAIL raw_lat3_valid[%0d]: got v=%b e=%b expected v=%b e=0", k, v3, e3, (k == 4));
        miscompares++;
      end
      if (k >= 4) begin
        vectors++;
        if (d3 !== 8'h3C) begin
          $display("FAIL raw_lat3_data[%0d]: got %h expected 3c", k, d3);
          miscompares++;
        end
      end
      if (k == 2) begin
        vectors++;
        if ({v1, e1, d1} !== {1'b1, 1'b0, 8'h3C}) begin
          $display("FAIL raw_lat1: got v=%b e=%b d=%h expected v=1 e=0 d=3c", v1, e1, d1);
          miscompares++;
        end
      end
      if (k == 3) begin
        vectors++;
        if ({v2, e2, d2} !== {1'b1, 1'b0, 8'h3C}) begin
          $display("FAIL raw_lat2: got v=%b e=%b d=%h expected v=1 e=0 d=3c", v2, e2, d2);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_alternating();
    logic       exp_v [5];
    logic [7:0] exp_d [5];
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_d = '{8'h3C, 8'h3C, 8'h11, 8'h11, 8'h22};
    flush();
    for (int k = 0; k < 5; k++) begin
      case (k)
        0:       drive(1'b1, 4'h0, 8'h11);
        1:       drive(1'b0, 4'h0, 8'h00);
        2:       drive(1'b1, 4'h1, 8'h22);
        3:       drive(1'b0, 4'h1, 8'h00);
        default: drive(1'b1, 4'hD, 8'hDD);
      endcase
      vectors++;
      if ({v1, e1, d1} !== {exp_v[k], 1'b0, exp_d[k]}) begin
        $display("FAIL alternating[%0d]: got v=%b e=%b d=%h expected v=%b e=0 d=%h",
                 k, v1, e1, d1, exp_v[k], exp_d[k]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid();
    flush();
    drive(1'b1, 4'h5, 8'h55);
    drive(1'b0, 4'h5, 8'h00);
    drive(1'b0, 4'h5, 8'h00);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({v2, e2, d2, v1, d1} !== 19'd0) begin
      $display("FAIL reset_mid_flush: got v2=%b e2=%b d2=%h v1=%b d1=%h expected all 0", v2, e2, d2, v1, d1);
      miscompares++;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'h5, 8'h00);
    vectors++;
    if (v2 !== 1'b0 || v1 !== 1'b0) begin
      $display("FAIL reset_mid_first_edge: got v1=%b v2=%b expected 0 0", v1, v2);
      miscompares++;
    end
    drive(1'b1, 4'hD, 8'hDD);
    vectors++;
    if ({v1, e1, d1, v2} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      $display("FAIL reset_mid_lat1: got v1=%b e1=%b d1=%h v2=%b expected 1 1 00 0", v1, e1, d1, v2);
      miscompares++;
    end
    drive(1'b1, 4'hD, 8'hDD);
    vectors++;
    if ({v2, e2, d2} !== {1'b1, 1'b1, 8'h00}) begin
      $display("FAIL reset_mid_lat2: got v=%b e=%b d=%h expected v=1 e=1 d=00", v2, e2, d2);
      miscompares++;
    end
  endtask

`ifdef MEM_RESPONDER_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70000; i++) drive(1'b1, 4'h0, 8'(i));
    vectors++;
    if ({wc1, rc1, ec1} !== {16'hFFFF, 16'h0000, 16'h0000}) begin
      $display("FAIL stats_wr_sat: got wr=%h rd=%h err=%h expected ffff 0000 0000", wc1, rc1, ec1);
      miscompares++;
    end
    drive(1'b0, 4'h1, 8'h00);
    drive(1'b0, 4'h2, 8'h00);
    drive(1'b0, 4'h3, 8'h00);
    flush();
    vectors++;
    if ({wc1, rc1, ec1} !== {16'hFFFF, 16'd3, 16'd3}) begin
      $display("FAIL stats_lat1: got wr=%h rd=%h err=%h expected ffff 0003 0003", wc1, rc1, ec1);
      miscompares++;
    end
    vectors++;
    if ({ec2, ec3, rc3} !== {16'd3, 16'd3, 16'd3}) begin
      $display("FAIL stats_lat23: got err2=%h err3=%h rd3=%h expected 0003 0003 0003", ec2, ec3, rc3);
      miscompares++;
    end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_unwritten_reads();
    test_back_to_back();
    test_raw_lat3();
    test_alternating();
    test_reset_mid();
`ifdef MEM_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
